uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single UART transmitter between several message sources, such as the LED-report and 7-segment-report generators and a future command echo. Each source presents a byte stream with a valid/ready/last handshake. Once a source is granted the transmitter, it keeps it for its whole message. The block paces each byte against the transmitter's busy flag, inserts a fixed idle gap between messages, and aborts a message whose source stalls.

---
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between several byte-stream sources.
// A granted source keeps the transmitter for its whole message; stalled sources are aborted.
module uart_tx_arbiter #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ena,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          active,
    output logic                          abort
);

    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    start_q, start_d;
    logic                    abort_q, abort_d;
    logic                    last_q, last_d;
    logic                    guard_q, guard_d;
    logic [STALL_W-1:0]      stall_q, stall_d;
    logic [GAP_W-1:0]        gap_q, gap_d;

    logic                    win_found;
    logic [PTR_W-1:0]        win_idx;
    logic [31:0]             arb_idx;
    logic [PTR_W-1:0]        arb_cand;
    logic [DATA_WIDTH-1:0]   owner_data;

    // First valid requester strictly after the previous owner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            arb_idx = 32'(ptr_q) + i;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            arb_cand = PTR_W'(arb_idx);
            if (!win_found && req_valid[arb_cand]) begin
                win_found = 1'b1;
                win_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ptr_q == PTR_W'(i)) owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        last_d  = last_q;
        guard_d = guard_q;
        stall_d = stall_q;
        gap_d   = gap_q;
        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        grant_d          = '0;
                        grant_d[win_idx] = 1'b1;
                        ptr_d            = win_idx;
                        stall_d          = '0;
                        state_d          = XFER;
                    end
                end
                XFER: begin
                    if (req_valid[ptr_q]) begin
                        data_d  = owner_data;
                        start_d = 1'b1;
                        last_d  = req_last[ptr_q];
                        stall_d = '0;
                        guard_d = 1'b1;
                        state_d = DRAIN;
                    end else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                        abort_d = 1'b1;
                        grant_d = '0;
                        stall_d = STALL_W'(TIMEOUT_CYCLES);
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // The UART may raise busy one cycle late, so the first DRAIN cycle ignores it.
                    if (guard_q) begin
                        guard_d = 1'b0;
                    end else if (!tx_busy) begin
                        if (last_q) begin
                            grant_d = '0;
                            gap_d   = '0;
                            state_d = GAP;
                        end else begin
                            stall_d = '0;
                            state_d = XFER;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
                    else gap_d = gap_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            data_q  <= '0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            last_q  <= 1'b0;
            guard_q <= 1'b0;
            stall_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            start_q <= start_d;
            abort_q <= abort_d;
            last_q  <= last_d;
            guard_q <= guard_d;
            stall_q <= stall_d;
            gap_q   <= gap_d;
        end
    end

    assign req_ready = grant_q & {NUM_REQ{ena && (state_q == XFER)}};
    assign tx_data   = data_q;
    assign tx_start  = start_q;
    assign grant     = grant_q;
    assign abort     = abort_q;
    assign active    = (state_q == XFER) || (state_q == DRAIN);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration table plus multi-cycle message scenarios
// driven by a small source model and a UART busy model.
module tb_uart_tx_arbiter;

    localparam int DW  = 8;
    localparam int NR  = 3;
    localparam int GAP = 16;
    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, ena, tx_busy, tx_start, active, abort;
    logic [NR-1:0]    req_valid, req_last, req_ready, grant;
    logic [NR*DW-1:0] req_data;
    logic [DW-1:0]    tx_data;

    uart_tx_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .ena(ena),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .grant(grant), .active(active), .abort(abort)
    );

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, bad = 0, acc_cnt = 0;
    int busy_len = 0, busy_cnt = 0;

    logic [7:0] src_bytes [NR][16];
    int         src_len [NR];
    int         src_pos [NR];
    bit         src_nolast [NR];

    int         start_cyc[$];
    logic [7:0] start_dat[$];
    logic [2:0] start_gnt[$];
    int         abort_cyc[$];
    int         rise_cyc[$];
    logic [2:0] rise_gnt[$];
    int         fall_cyc[$];

    logic [2:0] prev_gnt = '0, fire, s_grant, s_ready;
    logic       prev_start = 1'b0, s_start, s_active, s_abort;
    logic [7:0] s_data;

    typedef struct {
        logic [2:0] valid;
        logic       en;
        logic [2:0] exp_grant;
    } arb_vec_t;
    arb_vec_t vecs [8];

    logic [7:0] exp_ld [10] = '{8'h4C, 8'h44, 8'h3A, 8'h20, 8'h30, 8'h78, 8'h31, 8'h32, 8'h33, 8'h34};
    logic [7:0] exp_rr [8]  = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
    logic [2:0] exp_rg [8]  = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int dstart(int i, int j);
        return (start_cyc.size() > j) ? start_cyc[j] - start_cyc[i] : -1;
    endfunction

    function automatic int gap_len(int ri, int fi);
        return (rise_cyc.size() > ri && fall_cyc.size() > fi) ? rise_cyc[ri] - fall_cyc[fi] : -1;
    endfunction

    task automatic load_str(input int s, input string str);
        for (int k = 0; k < str.len(); k++) src_bytes[s][k] = str[k];
        src_len[s]    = str.len();
        src_pos[s]    = 0;
        src_nolast[s] = 1'b0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = (src_pos[i] < src_len[i]);
            req_data[i*DW +: DW]  = (src_pos[i] < src_len[i]) ? src_bytes[i][src_pos[i]] : 8'h00;
            req_last[i]           = (src_pos[i] == src_len[i] - 1) && !src_nolast[i];
        end
        tx_busy = (busy_cnt != 0);
    endtask

    task automatic clear_logs();
        start_cyc.delete(); start_dat.delete(); start_gnt.delete();
        abort_cyc.delete(); rise_cyc.delete(); rise_gnt.delete(); fall_cyc.delete();
        acc_cnt = 0;
    endtask

    // One clock cycle: drive, sample outputs at the falling edge, then advance the models.
    task automatic step();
        drive_inputs();
        @(negedge clk);
        s_grant = grant; s_ready = req_ready; s_start = tx_start;
        s_active = active; s_abort = abort; s_data = tx_data;
        fire = req_valid & req_ready;
        if (tx_start) begin
            start_cyc.push_back(cyc); start_dat.push_back(tx_data); start_gnt.push_back(grant);
        end
        if (abort) abort_cyc.push_back(cyc);
        if (grant != 0 && prev_gnt == 0) begin rise_cyc.push_back(cyc); rise_gnt.push_back(grant); end
        if (grant == 0 && prev_gnt != 0) fall_cyc.push_back(cyc);
        if ((!ena && req_ready != 0) || ((req_ready & ~grant) != 0) || (tx_start && prev_start)) bad++;
        prev_gnt = grant; prev_start = tx_start;
        if (fire != 0) acc_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) if (fire[i]) src_pos[i]++;
        if (s_start) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
    endtask

    task automatic do_reset();
        reset = 1'b1; ena = 1'b1;
        for (int i = 0; i < NR; i++) begin src_len[i] = 0; src_pos[i] = 0; src_nolast[i] = 1'b0; end
        busy_cnt = 0; busy_len = 0;
        step(); step();
        reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        int n0;
        logic [2:0] rdy_or;

        vecs[0] = '{3'b000, 1'b1, 3'b000};
        vecs[1] = '{3'b001, 1'b1, 3'b001};
        vecs[2] = '{3'b010, 1'b1, 3'b010};
        vecs[3] = '{3'b100, 1'b1, 3'b100};
        vecs[4] = '{3'b110, 1'b1, 3'b010};
        vecs[5] = '{3'b101, 1'b1, 3'b001};
        vecs[6] = '{3'b111, 1'b1, 3'b001};
        vecs[7] = '{3'b111, 1'b0, 3'b000};

        // Arbitration from reset: rr_ptr starts at the last source, so source 0 is searched first.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            ena = vecs[v].en;
            for (int i = 0; i < NR; i++) if (vecs[v].valid[i]) load_str(i, "Z");
            step(); step();
            check($sformatf("v%0d_grant", v),  32'(s_grant),  32'(vecs[v].exp_grant));
            check($sformatf("v%0d_ready", v),  32'(s_ready),  32'(vecs[v].exp_grant));
            check($sformatf("v%0d_active", v), 32'(s_active), 32'(vecs[v].exp_grant != 0));
            check($sformatf("v%0d_start", v),  32'(s_start),  32'(0));
            check($sformatf("v%0d_abort", v),  32'(s_abort),  32'(0));
            check($sformatf("v%0d_data", v),   32'(s_data),   32'(0));
        end

        // Single 10-byte message with a slow transmitter, then gap before the next grant.
        do_reset();
        busy_len = 20;
        load_str(0, "LD: 0x1234");
        for (int k = 0; k < 600 && !(start_cyc.size() == 10 && fall_cyc.size() >= 1); k++) step();
        check("t1_nstart", start_cyc.size(), 10);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t1_byte%0d", k), (k < start_dat.size()) ? 32'(start_dat[k]) : 32'hDEADBEEF, 32'(exp_ld[k]));
            check($sformatf("t1_gnt%0d", k),  (k < start_gnt.size()) ? 32'(start_gnt[k]) : 32'hDEADBEEF, 32'b001);
        end
        check("t1_single_grant", rise_cyc.size(), 1);
        load_str(1, "Q");
        for (int k = 0; k < 60 && rise_cyc.size() < 2; k++) step();
        check("t1_gap", gap_len(1, 0), GAP + 1);
        check("t1_next_gnt", (rise_gnt.size() > 1) ? 32'(rise_gnt[1]) : 32'hDEADBEEF, 32'b010);

        // Round robin with busy tied low; source 0 re-requests while source 2 holds the grant.
        do_reset();
        load_str(0, "ab"); load_str(1, "cd"); load_str(2, "ef");
        for (int k = 0; k < 200 && rise_gnt.size() < 3; k++) step();
        load_str(0, "gh");
        for (int k = 0; k < 300 && !(start_cyc.size() == 8 && rise_cyc.size() == 4); k++) step();
        check("t2_nstart", start_cyc.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_byte%0d", k), (k < start_dat.size()) ? 32'(start_dat[k]) : 32'hDEADBEEF, 32'(exp_rr[k]));
            check($sformatf("t2_gnt%0d", k),  (k < start_gnt.size()) ? 32'(start_gnt[k]) : 32'hDEADBEEF, 32'(exp_rg[k]));
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("t2_order%0d", k), (k < rise_gnt.size()) ? 32'(rise_gnt[k]) : 32'hDEADBEEF, 32'(exp_rg[2*k]));
        check("t2_pace0", dstart(0, 1), 3);
        check("t2_pace1", dstart(2, 3), 3);
        check("t2_gap0", gap_len(1, 0), GAP + 1);
        check("t2_gap1", gap_len(2, 1), GAP + 1);

        // Timeout: one byte without last, then the source goes silent.
        do_reset();
        load_str(1, "T");
        src_nolast[1] = 1'b1;
        for (int k = 0; k < 60 && abort_cyc.size() < 1; k++) step();
        load_str(2, "U");
        for (int k = 0; k < 60 && rise_cyc.size() < 2; k++) step();
        check("t3_nstart", start_cyc.size(), 1);
        check("t3_nabort", abort_cyc.size(), 1);
        check("t3_abort_time", (abort_cyc.size() > 0) ? abort_cyc[0] - start_cyc[0] : -1, 10);
        check("t3_grant_clr", (fall_cyc.size() > 0 && abort_cyc.size() > 0) ? fall_cyc[0] - abort_cyc[0] : -1, 0);
        check("t3_regrant", (rise_cyc.size() > 1 && abort_cyc.size() > 0) ? rise_cyc[1] - abort_cyc[0] : -1, GAP + 1);
        check("t3_regrant_src", (rise_gnt.size() > 1) ? 32'(rise_gnt[1]) : 32'hDEADBEEF, 32'b100);

        // Reset on the cycle after the third accept.
        do_reset();
        load_str(0, "0123456789");
        for (int k = 0; k < 40 && acc_cnt < 3; k++) step();
        check("t4_accepts", acc_cnt, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        load_str(0, "R"); load_str(1, "S");
        step();
        check("t4_grant",  32'(s_grant),  32'(0));
        check("t4_ready",  32'(s_ready),  32'(0));
        check("t4_start",  32'(s_start),  32'(0));
        check("t4_active", 32'(s_active), 32'(0));
        check("t4_abort",  32'(s_abort),  32'(0));
        check("t4_data",   32'(s_data),   32'(0));
        step();
        check("t4_rearb", 32'(s_grant), 32'b001);

        // ena freeze during DRAIN and during GAP.
        do_reset();
        busy_len = 3;
        load_str(0, "xyz");
        for (int k = 0; k < 20 && start_cyc.size() < 1; k++) step();
        n0 = start_cyc.size();
        rdy_or = '0;
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin step(); rdy_or |= s_ready; end
        ena = 1'b1;
        check("t5_drain_ready", 32'(rdy_or), 32'(0));
        check("t5_drain_nostart", start_cyc.size() - n0, 0);
        for (int k = 0; k < 100 && !(start_cyc.size() == 3 && fall_cyc.size() == 1); k++) step();
        check("t5_nstart", start_cyc.size(), 3);
        check("t5_byte0", (start_dat.size() > 0) ? 32'(start_dat[0]) : 32'hDEADBEEF, 32'h78);
        check("t5_byte1", (start_dat.size() > 1) ? 32'(start_dat[1]) : 32'hDEADBEEF, 32'h79);
        check("t5_byte2", (start_dat.size() > 2) ? 32'(start_dat[2]) : 32'hDEADBEEF, 32'h7A);
        check("t5_frozen_pace", dstart(0, 1), 8);
        load_str(1, "w");
        for (int k = 0; k < 3; k++) step();
        n0 = start_cyc.size();
        rdy_or = '0;
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin step(); rdy_or |= s_ready; end
        ena = 1'b1;
        check("t5_gap_ready", 32'(rdy_or), 32'(0));
        check("t5_gap_nostart", start_cyc.size() - n0, 0);
        for (int k = 0; k < 60 && rise_cyc.size() < 2; k++) step();
        check("t5_gap_len", gap_len(1, 0), GAP + 1 + 5);
        check("t5_next_gnt", (rise_gnt.size() > 1) ? 32'(rise_gnt[1]) : 32'hDEADBEEF, 32'b010);

        check("protocol_violations", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
